// File: rtl/encode_acc_requant_64s_16.sv
// Accumulates signed product beats per group, then rounds, shifts and
// saturates to a signed activation on a valid/ready output.
// Ports: clk, reset (async, low), ce; in_valid/in_ready/in_data/in_last/shift
// input beats; out_valid/out_ready/out_data/out_sat/out_count results.
module encode_acc_requant_64s_16 #(
  parameter int PROD_WIDTH  = 64,
  parameter int ACC_WIDTH   = 72,
  parameter int OUT_WIDTH   = 16,
  parameter int SHIFT_WIDTH = 6,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ce,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PROD_WIDTH-1:0]  in_data,
  input  logic                   in_last,
  input  logic [SHIFT_WIDTH-1:0] shift,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic                   out_sat,
  output logic [CNT_WIDTH-1:0]   out_count
);

  typedef enum logic [1:0] {
    ACCUM,
    ROUND,
    OUT
  } state_e;

  // Rounding/shift path is one bit wider than the accumulator so the
  // rounding increment cannot overflow.
  localparam int RW = ACC_WIDTH + 1;

  localparam logic signed [RW-1:0] QMAX =
    {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] QMIN = ~QMAX;

  state_e                 state_q;
  logic [ACC_WIDTH-1:0]   acc_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic                   first_q;
  logic [SHIFT_WIDTH-1:0] shift_q;
  logic                   out_valid_q;
  logic [OUT_WIDTH-1:0]   out_data_q;
  logic                   out_sat_q;
  logic [CNT_WIDTH-1:0]   out_count_q;

  logic                   acc_in;
  logic                   xfer;
  logic [ACC_WIDTH-1:0]   prod_ext;
  logic [ACC_WIDTH-1:0]   acc_sum;
  logic [CNT_WIDTH-1:0]   cnt_inc;

  logic signed [RW-1:0]   acc_w;
  logic signed [RW-1:0]   rnd;
  logic signed [RW-1:0]   r;
  logic signed [RW-1:0]   q;
  logic                   sat_hi;
  logic                   sat_lo;
  logic [OUT_WIDTH-1:0]   rq_data;

  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      ACCUM:   in_ready = ce;
      OUT:     in_ready = ce & out_ready;
      default: in_ready = 1'b0;
    endcase
    in_ready = in_ready & reset;
  end

  assign acc_in = ce & in_valid & in_ready;
  assign xfer   = ce & out_valid_q & out_ready;

  assign prod_ext = {{(ACC_WIDTH-PROD_WIDTH){in_data[PROD_WIDTH-1]}},
                     in_data};
  assign acc_sum  = (first_q ? '0 : acc_q) + prod_ext;
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    acc_w = $signed({acc_q[ACC_WIDTH-1], acc_q});
    rnd   = '0;
    if (shift_q != '0)
      rnd = $signed({{(RW-1){1'b0}}, 1'b1} << (shift_q - 1'b1));
    r      = acc_w + rnd;
    q      = r >>> shift_q;
    sat_hi = q > QMAX;
    sat_lo = q < QMIN;
    rq_data = q[OUT_WIDTH-1:0];
    if (sat_hi)
      rq_data = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    else if (sat_lo)
      rq_data = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      first_q     <= 1'b1;
      shift_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_count_q <= '0;
    end else if (ce) begin
      unique case (state_q)
        ACCUM: begin
          if (acc_in) begin
            acc_q   <= acc_sum;
            cnt_q   <= first_q ? CNT_WIDTH'(1) : cnt_inc;
            if (first_q)
              shift_q <= shift;
            // last beat re-arms the first-beat flag for the next group
            first_q <= in_last;
            if (in_last)
              state_q <= ROUND;
          end
        end
        ROUND: begin
          out_data_q  <= rq_data;
          out_sat_q   <= sat_hi | sat_lo;
          out_count_q <= cnt_q;
          out_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        OUT: begin
          if (xfer) begin
            out_valid_q <= 1'b0;
            // a beat taken alongside the transfer opens the next group
            if (acc_in) begin
              acc_q   <= prod_ext;
              cnt_q   <= CNT_WIDTH'(1);
              shift_q <= shift;
              first_q <= in_last;
              state_q <= in_last ? ROUND : ACCUM;
            end else begin
              first_q <= 1'b1;
              state_q <= ACCUM;
            end
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_encode_acc_requant_64s_16.sv
// Directed bench for encode_acc_requant_64s_16.
// Hand-computed groups, rounding, saturation, stall and reset cases.
module tb_encode_acc_requant_64s_16;

  logic        clk;
  logic        reset;
  logic        ce;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_last;
  logic [5:0]  shift;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sat;
  logic [15:0] out_count;

  int vec_cnt;
  int err_cnt;
  int cyc;
  int t0;
  bit tog;

  encode_acc_requant_64s_16 dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .shift     (shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_count (out_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input longint obs,
                       input longint exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint sd(input logic [15:0] v);
    return longint'($signed(v));
  endfunction

  task automatic send(input longint d, input logic last,
                      input logic [5:0] sh);
    bit ok;
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    shift    = sh;
    ok = 1'b0;
    n  = 0;
    do begin
      @(negedge clk);
      ok = ce && in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    check("accept", ok, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("valid_to", out_valid, 1);
  endtask

  task automatic result(input string tag, input longint ed,
                        input longint es, input longint ec);
    wait_valid();
    check({tag, "_data"}, sd(out_data), ed);
    check({tag, "_sat"}, out_sat, es);
    check({tag, "_cnt"}, out_count, ec);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_taken"}, out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_cnt   = 0;
    err_cnt   = 0;
    tog       = 1'b0;
    reset     = 1'b0;
    ce        = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    shift     = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", sd(out_data), 0);
    check("rst_sat", out_sat, 0);
    check("rst_count", out_count, 0);
    reset = 1'b1;
    #1;
    check("rel_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // basic group and latency
    send(100, 0, 0);
    send(-30, 0, 0);
    send(5, 1, 0);
    check("lat_round", out_valid, 0);
    @(posedge clk);
    #1;
    check("lat_out", out_valid, 1);
    result("grp3", 75, 0, 3);

    // requantisation and saturation
    send(98304, 1, 2);
    result("sh2", 24576, 0, 1);
    send(98304, 1, 1);
    result("sat_hi", 32767, 1, 1);
    send(-98304, 1, 1);
    result("sat_lo", -32768, 1, 1);

    // round half up at shift 2
    send(4, 0, 2);
    send(2, 1, 3);
    result("rnd6", 2, 0, 2);
    send(3, 0, 2);
    send(2, 1, 0);
    result("rnd5", 1, 0, 2);
    send(-4, 0, 2);
    send(-2, 1, 0);
    result("rndm6", -1, 0, 2);
    send(-7, 1, 2);
    result("rndm7", -2, 0, 1);

    // backpressure with overlapped transfer and first beat
    send(9, 1, 0);
    wait_valid();
    in_valid = 1'b1;
    in_data  = 7;
    in_last  = 1'b1;
    shift    = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_valid", out_valid, 1);
      check("bp_data", sd(out_data), 9);
      check("bp_cnt", out_count, 1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    check("bp_xfer", out_valid, 0);
    result("bp", 7, 0, 1);

    // reference latency with ce held high
    t0 = cyc;
    send(10, 0, 0);
    send(20, 0, 0);
    send(30, 0, 0);
    send(-5, 1, 0);
    wait_valid();
    check("ce1_edges", cyc - t0, 5);
    result("ce1", 55, 0, 4);

    // same group with ce toggling every cycle
    ce  = 1'b0;
    tog = 1'b1;
    t0  = cyc;
    fork
      begin
        while (tog) begin
          @(posedge clk);
          #1;
          ce = ~ce;
        end
      end
    join_none
    send(10, 0, 0);
    send(20, 0, 0);
    send(30, 0, 0);
    send(-5, 1, 0);
    wait_valid();
    check("cetog_edges", cyc - t0, 10);
    tog = 1'b0;
    @(posedge clk);
    #2;
    ce = 1'b1;
    @(posedge clk);
    #1;
    result("cetog", 55, 0, 4);

    // reset mid-group
    send(50, 0, 0);
    send(60, 0, 0);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", sd(out_data), 0);
    check("mid_rst_cnt", out_count, 0);
    check("mid_rst_ready", in_ready, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    send(3, 0, 0);
    send(4, 1, 0);
    result("post_rst", 7, 0, 2);

    // reset while a result is held
    send(11, 1, 0);
    wait_valid();
    #3;
    reset = 1'b0;
    #1;
    check("out_rst_valid", out_valid, 0);
    check("out_rst_data", sd(out_data), 0);
    check("out_rst_cnt", out_count, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    send(-1, 1, 0);
    result("post_rst2", -1, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec_cnt, err_cnt);
    $finish;
  end

endmodule
